instr_encoder_loader: RTL

Sequential MIPS instruction encoder and instruction-memory loader, the inverse of the instruction decoder. It accepts one symbolic instruction per handshake: a 4-bit instruction code plus operand fields. It packs the fields into a 32-bit MIPS word and writes it into the instruction-memory write port at consecutive word addresses. The testbench and boot path use it to place programs into IM without hand-assembled hex.

---
 rtl/instr_encoder_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instructions and streams them into IM at consecutive word addresses.
// Latency: handshake in cycle N -> im_we/im_addr/im_wdata in cycle N+1 (one registered write stage).
// Backpressure: in_ready is high only in RUN and drops once DEPTH words have been written (FULL).
module instr_encoder_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_instr,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_ill_q, err_ill_d;
    logic              err_full_q, err_full_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              hs;

    // Pack the operand fields of the offered instruction; unused fields are forced to zero
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        case (in_instr)
            4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
            4'd2:    enc_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
            4'd3:    enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
            4'd4:    enc_word = {6'h0D, in_rs, in_rt, in_imm};
            4'd5:    enc_word = {6'h23, in_rs, in_rt, in_imm};
            4'd6:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
            4'd7:    enc_word = {6'h04, in_rs, in_rt, in_imm};
            4'd8:    enc_word = {6'h0F, 5'd0, in_rt, in_imm};
            4'd9:    enc_word = {6'h03, in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state: start has priority over everything, then per-state handshake/finish handling
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cnt_d      = cnt_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;
        hs         = in_valid && (state_q == S_RUN);

        if (start) begin
            // Restart flushes the pending write by leaving we_d low
            state_d    = S_RUN;
            addr_d     = {base_addr[ADDR_W-1:2], 2'b00};
            cnt_d      = 16'd0;
            err_ill_d  = 1'b0;
            err_full_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hs) begin
                        if (enc_legal) begin
                            we_d      = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = enc_word;
                            addr_d    = addr_q + ADDR_W'(4);
                            cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                            if (cnt_q == 16'(DEPTH - 1)) begin
                                state_d = S_FULL;
                            end
                        end else begin
                            err_ill_d = 1'b1;
                        end
                    end
                    if (finish) begin
                        state_d = S_DONE;
                    end
                end
                S_FULL: begin
                    if (in_valid) begin
                        err_full_d = 1'b1;
                    end
                    if (finish) begin
                        state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and write-stage registers; reset drops any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            cnt_q      <= 16'd0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cnt_q      <= cnt_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
        end
    end

    // Outputs are decoded from registered state only
    always_comb begin
        in_ready    = (state_q == S_RUN);
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        im_we       = we_q;
        im_addr     = wr_addr_q;
        im_wdata    = wr_data_q;
        word_count  = cnt_q;
        err_illegal = err_ill_q;
        err_full    = err_full_q;
    end

endmodule
